chunk_interp_scheduler: RTL and testbench
=========================================

// Module: chunk_interp_scheduler
// PURPOSE
//   Sequences the chunk processing datapath (interpolator + two upscalers) for 2x frame-rate output.
//   - Accepts (last_chunk, current_chunk) pairs over a valid/ready handshake.
//   - Holds each pair stable on the processor inputs.
//   - Serialises the two upscaled results onto one frame-buffer write port:
//     the interpolated chunk first (buffer 1), then the passthrough chunk (buffer 0).
//   - Tracks chunk index within a frame and flags frame completion / framing errors.
// PARAMETERS
//   CHUNKS_PER_FRAME  default 14400  chunks per frame; chunk index wraps after CHUNKS_PER_FRAME-1
//   IDX_W             default 14     width of chunk index / write address; must hold CHUNKS_PER_FRAME-1
// PORTS
//   clk                 in   1             single clock; all logic rising-edge
//   rst_n               in   1             asynchronous, active-low reset
//   in_valid            in   1             input pair valid
//   in_ready            out  1             scheduler can accept a pair
//   in_last_chunk       in   chunk_input   same-position chunk of previous frame
//   in_current_chunk    in   chunk_input   chunk of current frame
//   in_eof              in   1             pair is the final chunk of its frame
//   proc_last_chunk     out  chunk_input   to processor last_chunk (registered)
//   proc_current_chunk  out  chunk_input   to processor current_chunk (registered)
//   proc_out_current    in   chunk_output  from processor output_chunk_current
//   proc_out_next       in   chunk_output  from processor output_chunk_next
//   wr_valid            out  1             write request valid
//   wr_ready            in   1             frame-buffer writer accepts
//   wr_data             out  chunk_output  chunk to write
//   wr_buf              out  1             1 = interpolated buffer, 0 = current buffer
//   wr_addr             out  IDX_W         chunk index within frame
//   frame_done          out  1             one-cycle pulse after last chunk of a frame is written
//   framing_err         out  1             one-cycle pulse on in_eof / index mismatch
// BEHAVIOUR
//   Reset values:
//     - state=IDLE, in_ready=1, wr_valid=0, wr_buf=0, wr_addr=0.
//     - frame_done=0, framing_err=0, proc_* regs=0, chunk_idx=0, first_frame=1.
//   State machine:
//     - IDLE: in_ready=1, wr_valid=0.
//       - On in_valid&&in_ready: register proc_current_chunk<=in_current_chunk and eof_q<=in_eof.
//       - Same edge: proc_last_chunk<=(first_frame ? in_current_chunk : in_last_chunk).
//       - Go to EMIT_NEXT.
//     - EMIT_NEXT: in_ready=0, wr_valid=1, wr_buf=1, wr_data=proc_out_next, wr_addr=chunk_idx.
//       - On wr_ready: go to EMIT_CURR.
//     - EMIT_CURR: in_ready=0, wr_valid=1, wr_buf=0, wr_data=proc_out_current, wr_addr=chunk_idx.
//       - On wr_ready: go to IDLE and update chunk_idx (see index rules).
//   Timing:
//     - wr_data is combinational from the processor; its inputs are registered, so it is stable while wr_valid=1.
//     - Accept edge to wr_valid=1 is 1 cycle.
//     - Min 3 cycles per pair with wr_ready held 1; wr_valid stays high and wr_* stay stable under backpressure.
//   Index rules (evaluated at EMIT_CURR handshake):
//     - is_last = (chunk_idx==CHUNKS_PER_FRAME-1).
//     - eof_q && is_last: chunk_idx<=0, first_frame<=0, frame_done=1 next cycle.
//     - eof_q && !is_last: framing_err=1, frame_done=1, chunk_idx<=0, first_frame<=0 (early frame end).
//     - !eof_q && is_last: framing_err=1, frame_done=1, chunk_idx<=0, first_frame<=0 (wrap anyway).
//     - Otherwise: chunk_idx<=chunk_idx+1.
//   First frame after reset: interpolated buffer receives the upscaled current chunk (copy), so both buffers are valid.
//   Reset mid-operation: pending write dropped immediately (wr_valid=0); partial frame discarded; next frame treated as first.
//   in_valid while in_ready=0: ignored; the upstream holds the pair.
// TESTING
//   1. Reset, one pair with wr_ready=1 -> in_ready low 2 cycles; wr_buf sequence 1 then 0, both wr_addr=0; wr_data equals processor outputs.
//   2. First frame, last=0xAA.., current=0x55.. -> buffer-1 data equals upscaled 0x55.. (last ignored); second frame uses supplied last.
//   3. CHUNKS_PER_FRAME=4, 4 pairs with eof on 4th -> wr_addr 0,0,1,1,2,2,3,3; frame_done one cycle after 8th write; idx back to 0.
//   4. wr_ready low 5 cycles during EMIT_NEXT -> wr_valid, wr_buf=1, wr_data, wr_addr held; in_ready stays 0; no extra writes.
//   5. CHUNKS_PER_FRAME=4, eof on 2nd pair -> framing_err and frame_done pulse; next pair written at wr_addr=0.
//   6. rst_n low during EMIT_CURR -> wr_valid=0 immediately; after release in_ready=1, wr_addr=0, first-frame copy behaviour.

Source files
------------

// File: rtl/chunk_interp_scheduler.sv
// chunk_interp_scheduler
//   Sequences the chunk processing datapath (interpolator + two upscalers)
//   for 2x frame-rate output. A (last, current) chunk pair is taken over a
//   valid/ready handshake and held in registers that feed the processor. The
//   processor's two upscaled results are then serialised onto one
//   frame-buffer write port:
//     1. the interpolated chunk  -> buffer 1
//     2. the passthrough chunk   -> buffer 0
//   The block tracks the chunk index within the frame. It pulses frame_done
//   when a frame completes, and pulses framing_err when in_eof disagrees
//   with the index.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   in_valid/in_ready    input pair handshake
//   in_last_chunk        same-position chunk of the previous frame
//   in_current_chunk     chunk of the current frame
//   in_eof               pair is the final chunk of its frame
//   proc_last_chunk      registered processor input
//   proc_current_chunk   registered processor input
//   proc_out_current     upscaled current chunk from the processor
//   proc_out_next        upscaled interpolated chunk from the processor
//   wr_valid/wr_ready    frame-buffer write handshake
//   wr_data, wr_buf, wr_addr  write payload (wr_buf: 1 = interpolated)
//   frame_done           1-cycle pulse after the last write of a frame
//   framing_err          1-cycle pulse when in_eof disagrees with the index
module chunk_interp_scheduler #(
  parameter int CHUNKS_PER_FRAME = 14400,
  parameter int IDX_W            = 14,
  parameter int NUM_LANES        = 4,
  parameter int VEC_W            = 8,
  parameter int OVEC_W           = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]    in_last_chunk,
  input  logic [NUM_LANES-1:0][VEC_W-1:0]    in_current_chunk,
  input  logic                               in_eof,
  output logic [NUM_LANES-1:0][VEC_W-1:0]    proc_last_chunk,
  output logic [NUM_LANES-1:0][VEC_W-1:0]    proc_current_chunk,
  input  logic [NUM_LANES-1:0][OVEC_W-1:0]   proc_out_current,
  input  logic [NUM_LANES-1:0][OVEC_W-1:0]   proc_out_next,
  output logic                               wr_valid,
  input  logic                               wr_ready,
  output logic [NUM_LANES-1:0][OVEC_W-1:0]   wr_data,
  output logic                               wr_buf,
  output logic [IDX_W-1:0]                   wr_addr,
  output logic                               frame_done,
  output logic                               framing_err
);

  typedef enum logic [1:0] {IDLE, EMIT_NEXT, EMIT_CURR} state_t;

  state_t             state, state_nxt;
  logic               accept, curr_hs, is_last, eof_q, first_frame, sel_next;
  logic [IDX_W-1:0]   chunk_idx;

  assign accept  = in_valid && in_ready;
  assign curr_hs = (state == EMIT_CURR) && wr_ready;
  assign is_last = (chunk_idx == IDX_W'(CHUNKS_PER_FRAME - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept)   state_nxt = EMIT_NEXT;
      EMIT_NEXT: if (wr_ready) state_nxt = EMIT_CURR;
      EMIT_CURR: if (wr_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Outputs. Reset forces IDLE asynchronously, so a pending write is
  // dropped in the same cycle that rst_n falls.
  always_comb begin
    in_ready = 1'b0;
    wr_valid = 1'b0;
    sel_next = 1'b0;
    case (state)
      IDLE:      in_ready = 1'b1;
      EMIT_NEXT: begin wr_valid = 1'b1; sel_next = 1'b1; end
      EMIT_CURR: wr_valid = 1'b1;
      default:   in_ready = 1'b0;
    endcase
  end

  assign wr_buf  = sel_next;
  assign wr_addr = chunk_idx;

  // Per-lane input hold registers and write-data select. In the first
  // frame after reset there is no previous frame, so the current chunk
  // stands in for last. The "interpolated" buffer then receives a copy of
  // the current chunk, and both buffers start out valid.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        proc_last_chunk[l]    <= '0;
        proc_current_chunk[l] <= '0;
      end else if (accept) begin
        proc_current_chunk[l] <= in_current_chunk[l];
        proc_last_chunk[l]    <= first_frame ? in_current_chunk[l]
                                             : in_last_chunk[l];
      end
    end
    // The processor inputs are registered, so this data stays stable for
    // as long as wr_valid is held.
    assign wr_data[l] = sel_next ? proc_out_next[l] : proc_out_current[l];
  end

  // Frame tracking. A frame ends on in_eof or on index wrap, whichever
  // comes first. When the two disagree, the frame still ends and
  // framing_err is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eof_q       <= 1'b0;
      chunk_idx   <= '0;
      first_frame <= 1'b1;
      frame_done  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (accept) eof_q <= in_eof;
      frame_done  <= curr_hs && (eof_q || is_last);
      framing_err <= curr_hs && (eof_q != is_last);
      if (curr_hs) begin
        if (eof_q || is_last) begin
          chunk_idx   <= '0;
          first_frame <= 1'b0;
        end else begin
          chunk_idx   <= chunk_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunk_interp_scheduler.sv
module tb_chunk_interp_scheduler;
  localparam int CPF = 4;
  localparam int IW  = 2;

  typedef logic [3:0][7:0]  cin_t;
  typedef logic [3:0][15:0] cout_t;
  typedef struct packed {logic b; logic [IW-1:0] a; logic [63:0] d;} wr_t;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_eof = 0, wr_ready = 1;
  cin_t in_last_chunk = '0, in_current_chunk = '0;
  logic in_ready, wr_valid, wr_buf, frame_done, framing_err;
  cin_t proc_last_chunk, proc_current_chunk;
  cout_t proc_out_current, proc_out_next, wr_data;
  logic [IW-1:0] wr_addr;

  int compared = 0, mismatched = 0, n_writes = 0, n_expected = 0;
  int m_idx = 0;
  bit m_first = 1;
  wr_t sb[$];

  always #5 clk = ~clk;

  // Processor model: upscale duplicates each byte; interpolation mixes last and current.
  function automatic cout_t f_up(input cin_t c);
    cout_t r;
    for (int i = 0; i < 4; i++) r[i] = {c[i], c[i]};
    return r;
  endfunction
  function automatic cout_t f_interp(input cin_t l, input cin_t c);
    cout_t r;
    for (int i = 0; i < 4; i++) r[i] = {l[i] ^ 8'h3C, c[i]};
    return r;
  endfunction

  assign proc_out_current = f_up(proc_current_chunk);
  assign proc_out_next    = f_interp(proc_last_chunk, proc_current_chunk);

  chunk_interp_scheduler #(.CHUNKS_PER_FRAME(CPF), .IDX_W(IW), .NUM_LANES(4),
                           .VEC_W(8), .OVEC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last_chunk(in_last_chunk), .in_current_chunk(in_current_chunk),
    .in_eof(in_eof), .proc_last_chunk(proc_last_chunk),
    .proc_current_chunk(proc_current_chunk), .proc_out_current(proc_out_current),
    .proc_out_next(proc_out_next), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_buf(wr_buf), .wr_addr(wr_addr),
    .frame_done(frame_done), .framing_err(framing_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every accepted write must match the queue head.
  always @(negedge clk) begin
    #2;
    if (rst_n && wr_valid && wr_ready) begin
      wr_t e;
      n_writes++;
      chk("wr_unexpected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_buf", 64'(wr_buf), 64'(e.b));
        chk("wr_addr", 64'(wr_addr), 64'(e.a));
        chk("wr_data", wr_data, e.d);
      end
    end
  end

  // Push both expected writes of a pair; return the expected frame flags.
  task automatic push_exp(input cin_t l, input cin_t c, input logic eof,
                          output logic exp_done, output logic exp_err);
    bit last_pos;
    sb.push_back('{b: 1'b1, a: IW'(m_idx), d: f_interp(m_first ? c : l, c)});
    sb.push_back('{b: 1'b0, a: IW'(m_idx), d: f_up(c)});
    n_expected += 2;
    last_pos = (m_idx == CPF - 1);
    exp_done = eof || last_pos;
    exp_err  = eof != last_pos;
    if (exp_done) begin m_idx = 0; m_first = 0; end
    else m_idx++;
  endtask

  // Called at a negedge with the DUT idle; stalls the first write bp cycles.
  task automatic send_pair(input cin_t l, input cin_t c, input logic eof, input int bp);
    logic ed, ee;
    int n;
    wr_t head;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    push_exp(l, c, eof, ed, ee);
    head = sb[sb.size() - 2];
    in_last_chunk = l; in_current_chunk = c; in_eof = eof; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_eof = 0;
    chk("pulse_clear", 64'({frame_done, framing_err}), 64'd0);
    n = 0;
    if (bp > 0) wr_ready = 0;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk); n++;
      chk("bp_valid", 64'({wr_valid, wr_buf, in_ready}), 64'b110);
      chk("bp_addr", 64'(wr_addr), 64'(head.a));
      chk("bp_data", wr_data, head.d);
    end
    if (bp > 0) begin @(posedge clk); #1; wr_ready = 1; end
    do begin @(negedge clk); n++; end while (in_ready !== 1'b1 && n < 100);
    chk("busy_cycles", 64'(n), 64'(3 + bp));
    chk("frame_done", 64'(frame_done), 64'(ed));
    chk("framing_err", 64'(framing_err), 64'(ee));
    chk("idx_after", 64'(wr_addr), 64'(m_idx));
  endtask

  initial begin
    logic d, e;
    cin_t aa, c55;
    aa = {4{8'hAA}}; c55 = {4{8'h55}};
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_buf", 64'(wr_buf), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_pulses", 64'({frame_done, framing_err}), 64'd0);
    chk("rst_proc", 64'({proc_last_chunk, proc_current_chunk}), 64'd0);
    @(negedge clk); rst_n = 1;

    // Frame 1 (first after reset): buffer 1 gets a copy of current.
    send_pair(aa, c55, 0, 0);
    send_pair(cin_t'($urandom), cin_t'($urandom), 0, 0);
    send_pair(cin_t'($urandom), cin_t'($urandom), 0, 0);
    send_pair(cin_t'($urandom), cin_t'($urandom), 1, 0);   // clean frame end

    // Frame 2: supplied last is used; early eof under backpressure.
    send_pair(aa, c55, 0, 0);
    send_pair(cin_t'($urandom), cin_t'($urandom), 1, 5);

    // Frame 3: no eof at index wrap.
    for (int i = 0; i < 4; i++) send_pair(cin_t'($urandom), cin_t'($urandom), 0, 0);

    // Reset while EMIT_CURR is pending.
    chk("pre_rst_ready", 64'(in_ready), 64'd1);
    in_last_chunk = cin_t'($urandom); in_current_chunk = cin_t'($urandom); in_valid = 1;
    push_exp(in_last_chunk, in_current_chunk, 1'b0, d, e);
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1; wr_ready = 0;
    chk("curr_pending", 64'({wr_valid, wr_buf}), 64'b10);
    #2; rst_n = 0; #1;
    chk("rst_mid_valid", 64'(wr_valid), 64'd0);
    chk("rst_mid_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_addr", 64'(wr_addr), 64'd0);
    n_expected -= sb.size();
    sb.delete(); m_idx = 0; m_first = 1;
    @(negedge clk); rst_n = 1; wr_ready = 1;
    send_pair(aa, c55, 0, 0);   // first-frame copy again

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("write_count", 64'(n_writes), 64'(n_expected));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
